// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side responder for the core's load/store handshake.
// Takes single-cycle read/write requests from the decoder, runs each one on
// an external req/ack bus (with optional ack timeout), and reports back via
// mem_busy (stall) and mem_ready (read data valid). All outputs are flops.
module mem_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_read,
    input  logic              ram_write,
    input  logic              ram_read_done,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_busy,
    output logic              mem_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err
);

    // Counter only needs to hold 0..TIMEOUT-1; it fires on the last waiting cycle.
    localparam int CNT_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_READY = 2'd2,
        WR_WAIT  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               timeout_hit;
    logic               busy_n, ready_n, req_n, we_n, err_n;
    logic [DATA_W-1:0]  rdata_n, wdata_n;
    logic [ADDR_W-1:0]  addr_n;

    // Timeout fires when this waiting cycle is the TIMEOUT-th one; 0 disables it.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Register state, counter and every output; reset abandons any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_busy  <= 1'b0;
            mem_ready <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_err   <= 1'b0;
            rdata     <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mem_busy  <= busy_n;
            mem_ready <= ready_n;
            bus_req   <= req_n;
            bus_we    <= we_n;
            bus_err   <= err_n;
            rdata     <= rdata_n;
            bus_addr  <= addr_n;
            bus_wdata <= wdata_n;
        end
    end

    // Next-state and next-output logic; bus_ack is only looked at while waiting.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = 1'b0;
        we_n    = bus_we;
        rdata_n = rdata;
        addr_n  = bus_addr;
        wdata_n = bus_wdata;

        case (state)
            IDLE: begin
                // A write takes priority; a simultaneous read is dropped.
                if (ram_write) begin
                    addr_n  = addr;
                    wdata_n = wdata;
                    we_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = WR_WAIT;
                end else if (ram_read) begin
                    addr_n  = addr;
                    we_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus_ack) begin
                    rdata_n = bus_rdata;
                    state_n = RD_READY;
                end else if (timeout_hit) begin
                    rdata_n = '1;
                    err_n   = 1'b1;
                    state_n = RD_READY;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RD_READY: begin
                if (ram_read_done) state_n = IDLE;
            end
            WR_WAIT: begin
                if (bus_ack || timeout_hit) begin
                    err_n   = !bus_ack;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n  = (state_n == RD_WAIT) || (state_n == WR_WAIT);
        req_n   = busy_n;
        ready_n = (state_n == RD_READY);
    end

endmodule
